// File: rtl/stone_drawer.sv
// rtl/stone_drawer.sv - rasterises visible stones from the stone RAM into the VGA plotter
module stone_drawer #(
    parameter int         SPRITE_SIZE = 16,
    parameter int         MAX_X       = 320,
    parameter int         MAX_Y       = 240,
    parameter logic [2:0] COL_STONE   = 3'b111,
    parameter logic [2:0] COL_GOLD    = 3'b110,
    parameter logic [2:0] COL_DIAMOND = 3'b011
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] ram_q,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int         SW      = $clog2(SPRITE_SIZE);
    localparam logic [9:0] X_LIMIT = 10'(MAX_X);
    localparam logic [8:0] Y_LIMIT = 9'(MAX_Y);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_PLOT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    index_q;
    logic [3:0]    quantity_q;
    logic [8:0]    ent_x_q;
    logic [7:0]    ent_y_q;
    logic [1:0]    ent_type_q;
    logic [SW-1:0] dx_q;
    logic [SW-1:0] dy_q;
    logic [8:0]    last_x_q;
    logic [7:0]    last_y_q;
    logic [2:0]    last_colour_q;

    logic [9:0] x_sum;
    logic [8:0] y_sum;
    logic       clipped;
    logic       sprite_end;
    logic       last_entry;
    logic [2:0] type_colour;

    // Only X, Y, type and visible are meaningful; the moving flag and spare bits are ignored.
    logic unused_ram_bits;
    assign unused_ram_bits = ^{ram_q[22:19], ram_q[10:4], ram_q[0]};

    // Pixel position is formed one bit wider so off-screen sums clip instead of wrapping.
    assign x_sum      = {1'b0, ent_x_q} + {{(10 - SW){1'b0}}, dx_q};
    assign y_sum      = {1'b0, ent_y_q} + {{(9 - SW){1'b0}}, dy_q};
    assign clipped    = (x_sum >= X_LIMIT) || (y_sum >= Y_LIMIT);
    assign sprite_end = (dx_q == '1) && (dy_q == '1);
    assign last_entry = ({1'b0, index_q} + 5'd1) >= {1'b0, quantity_q};

    // Type-to-colour map; both diamond encodings share a colour.
    always_comb begin
        type_colour = COL_DIAMOND;
        case (ent_type_q)
            2'b00:   type_colour = COL_STONE;
            2'b01:   type_colour = COL_GOLD;
            default: type_colour = COL_DIAMOND;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one state per cycle except PLOT, which runs the full sprite raster.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (quantity != 4'd0) ? S_ADDR : S_DONE;
            S_ADDR:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = ram_q[1] ? S_PLOT : S_NEXT;
            S_PLOT:  if (sprite_end) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = last_entry ? S_DONE : S_ADDR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Entry walk, latched entry, raster counters and held pixel outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            index_q       <= '0;
            quantity_q    <= '0;
            ent_x_q       <= '0;
            ent_y_q       <= '0;
            ent_type_q    <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            last_colour_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quantity_q <= quantity;
                        index_q    <= '0;
                    end
                end
                S_LATCH: begin
                    ent_x_q    <= ram_q[31:23];
                    ent_y_q    <= ram_q[18:11];
                    ent_type_q <= ram_q[3:2];
                    dx_q       <= '0;
                    dy_q       <= '0;
                end
                S_PLOT: begin
                    dx_q <= dx_q + 1'b1;
                    if (dx_q == '1) dy_q <= dy_q + 1'b1;
                    if (!clipped) begin
                        last_x_q      <= x_sum[8:0];
                        last_y_q      <= y_sum[7:0];
                        last_colour_q <= type_colour;
                    end
                end
                S_NEXT: begin
                    if (!last_entry) index_q <= index_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: live pixel while strobing, otherwise the last plotted pixel.
    always_comb begin
        busy            = (state == S_ADDR) || (state == S_WAIT) || (state == S_LATCH) ||
                          (state == S_PLOT) || (state == S_NEXT);
        draw_stone_flag = busy;
        draw_index      = index_q;
        done            = (state == S_DONE);
        plot            = (state == S_PLOT) && !clipped;
        x               = plot ? x_sum[8:0] : last_x_q;
        y               = plot ? y_sum[7:0] : last_y_q;
        colour          = plot ? type_colour : last_colour_q;
    end

endmodule

// File: tb/tb_stone_drawer.sv
// tb/tb_stone_drawer.sv - randomized self-checking bench for stone_drawer
module tb_stone_drawer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] ram_q;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    stone_drawer dut (
        .clock           (clock),
        .resetn          (resetn),
        .start           (start),
        .quantity        (quantity),
        .ram_q           (ram_q),
        .draw_stone_flag (draw_stone_flag),
        .draw_index      (draw_index),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    // Stone RAM with two cycles of read latency.
    logic [31:0] mem [16];
    logic [31:0] ram_stage;
    always @(posedge clock) begin
        ram_stage <= mem[draw_index];
        ram_q     <= ram_stage;
    end

    typedef struct {
        int         k;
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t       exp_q[$];
    int         exp_done_k;
    logic [8:0] m_last_x;
    logic [7:0] m_last_y;
    logic [2:0] m_last_c;

    function automatic logic [31:0] mk_entry(input int ex, input int ey, input int et,
                                             input int vis, input int mov);
        logic [31:0] e;
        e        = $urandom;
        e[31:23] = 9'(ex);
        e[18:11] = 8'(ey);
        e[3:2]   = 2'(et);
        e[1]     = vis[0];
        e[0]     = mov[0];
        return e;
    endfunction

    function automatic logic [2:0] type_col(input logic [1:0] t);
        if (t == 2'b00) return 3'b111;
        if (t == 2'b01) return 3'b110;
        return 3'b011;
    endfunction

    // Expected plot stream for one pass; k counts cycles after the start cycle.
    task automatic build_expected(input int q);
        int   a;
        pix_t p;
        exp_q.delete();
        a = 1;
        for (int i = 0; i < q; i++) begin
            if (mem[i][1]) begin
                for (int dy = 0; dy < 16; dy++) begin
                    for (int dx = 0; dx < 16; dx++) begin
                        int xs, ys;
                        xs = int'(mem[i][31:23]) + dx;
                        ys = int'(mem[i][18:11]) + dy;
                        if (xs < 320 && ys < 240) begin
                            p.k  = a + 3 + dy * 16 + dx;
                            p.px = 9'(xs);
                            p.py = 8'(ys);
                            p.pc = type_col(mem[i][3:2]);
                            exp_q.push_back(p);
                        end
                    end
                end
                a += 260;
            end else begin
                a += 4;
            end
        end
        exp_done_k = a;
    endtask

    task automatic run_pass(input string name, input int q, input int restart_k);
        int obs_n, pix_err, busy_err, done_cnt, done_k, flag_seen;
        build_expected(q);
        obs_n = 0; pix_err = 0; busy_err = 0; done_cnt = 0; done_k = -1; flag_seen = 0;
        @(negedge clock);
        quantity = 4'(q);
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= exp_done_k + 20; k++) begin
            logic exp_busy;
            exp_busy = (k < exp_done_k);
            if (plot === 1'b1) begin
                if (obs_n >= exp_q.size()) pix_err++;
                else if (exp_q[obs_n].k != k || x !== exp_q[obs_n].px ||
                         y !== exp_q[obs_n].py || colour !== exp_q[obs_n].pc) pix_err++;
                obs_n++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (draw_stone_flag === 1'b1) flag_seen++;
            if (busy !== exp_busy || draw_stone_flag !== exp_busy) busy_err++;
            if (k == restart_k) begin
                start    = 1'b1;
                quantity = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        quantity = 4'(q);
        if (exp_q.size() > 0) begin
            m_last_x = exp_q[exp_q.size() - 1].px;
            m_last_y = exp_q[exp_q.size() - 1].py;
            m_last_c = exp_q[exp_q.size() - 1].pc;
        end

        n_tests++;
        if (obs_n != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s plot_count got=%0d want=%0d", name, obs_n, exp_q.size());
        end
        n_tests++;
        if (pix_err != 0) begin
            n_fail++;
            $display("FAIL %s pixel_stream errors=%0d want=0", name, pix_err);
        end
        n_tests++;
        if (done_cnt != 1 || done_k != exp_done_k) begin
            n_fail++;
            $display("FAIL %s done got_count=%0d got_cycle=%0d want_count=1 want_cycle=%0d",
                     name, done_cnt, done_k, exp_done_k);
        end
        n_tests++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s busy_flag bad_cycles=%0d want=0", name, busy_err);
        end
        n_tests++;
        if (x !== m_last_x || y !== m_last_y || colour !== m_last_c) begin
            n_fail++;
            $display("FAIL %s held_pixel got=%0d,%0d,%0d want=%0d,%0d,%0d",
                     name, x, y, colour, m_last_x, m_last_y, m_last_c);
        end
        if (q == 0) begin
            n_tests++;
            if (flag_seen != 0) begin
                n_fail++;
                $display("FAIL %s flag_never_high got=%0d want=0", name, flag_seen);
            end
        end
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        start    = 1'b0;
        quantity = 4'd0;
        m_last_x = '0; m_last_y = '0; m_last_c = '0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({draw_stone_flag, draw_index, x, y, colour, plot, busy, done} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {draw_stone_flag, draw_index, x, y, colour, plot, busy, done});
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single;
        mem[0] = mk_entry(100, 50, 1, 1, 0);
        run_pass("single", 1, 0);
    endtask

    task automatic test_invisible;
        mem[0] = mk_entry(20, 30, 2, 1, 1);
        mem[1] = mk_entry(60, 70, 0, 0, 0);
        mem[2] = mk_entry(200, 100, 3, 1, 0);
        run_pass("invisible", 3, 0);
        n_tests++;
        if (exp_done_k != 525 || exp_q.size() != 512) begin
            n_fail++;
            $display("FAIL invisible_model_len got=%0d want=525", exp_done_k);
        end
    endtask

    task automatic test_clip;
        mem[0] = mk_entry(310, 230, 0, 1, 0);
        run_pass("clip", 1, 0);
        n_tests++;
        if (exp_q.size() != 100) begin
            n_fail++;
            $display("FAIL clip_strobes got=%0d want=100", exp_q.size());
        end
    endtask

    task automatic test_zero;
        run_pass("zero", 0, 0);
    endtask

    task automatic test_restart;
        mem[0] = mk_entry(5, 5, 1, 1, 0);
        mem[1] = mk_entry(40, 8, 0, 0, 1);
        run_pass("restart", 2, 100);
    endtask

    task automatic test_reset_mid;
        int bad;
        mem[0] = mk_entry(10, 10, 2, 1, 0);
        mem[1] = mk_entry(50, 10, 0, 1, 0);
        @(negedge clock);
        quantity = 4'd2;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (50) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({plot, busy, draw_stone_flag, done} !== 4'b0 || x !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid got plot=%b busy=%b flag=%b done=%b x=%0d want 0",
                     plot, busy, draw_stone_flag, done, x);
        end
        resetn = 1'b1;
        m_last_x = '0; m_last_y = '0; m_last_c = '0;
        bad = 0;
        repeat (600) begin
            @(negedge clock);
            if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet bad_cycles=%0d want=0", bad);
        end
        run_pass("after_reset", 2, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            int q;
            q = $urandom_range(1, 6);
            for (int i = 0; i < 16; i++) begin
                int ex, ey;
                ex = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 330);
                ey = ($urandom_range(0, 3) == 0) ? $urandom_range(225, 255) : $urandom_range(0, 245);
                mem[i] = mk_entry(ex, ey, $urandom_range(0, 3), $urandom_range(0, 1),
                                  $urandom_range(0, 1));
            end
            run_pass("random", q, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_invisible();
        test_clip();
        test_zero();
        test_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
